cook_timer_fsm: RTL and testbench

// Kitchen-timer controller that consumes the one-cycle 1 s strobe produced by the clock

---
 rtl/cook_timer_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_cook_timer_fsm.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cook_timer_fsm
//  Description : Kitchen-timer controller. The user sets MM:SS with button
//                pulses, then the time counts down in BCD on each 1 s strobe.
//                An alarm is raised at 00:00 and cleared automatically after
//                ALARM_SEC strobes, or at once by any button.
//  Ports       : clk, reset_p (async, active-high)
//                tick_sec                 - one-clk 1 s strobe
//                btn_start/inc_min/inc_sec/clear - one-clk button pulses
//                min10, min1, sec10, sec1 - BCD time digits
//                state                    - 0=IDLE 1=RUN 2=PAUSE 3=ALARM
//                alarm                    - high while in ALARM
//  Revision    : 1.0 - initial release
// ============================================================================
module cook_timer_fsm #(
    parameter int ALARM_SEC = 10,
    parameter int MAX_MIN   = 59
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_inc_min,
    input  logic       btn_inc_sec,
    input  logic       btn_clear,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic [1:0] state,
    output logic       alarm
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_ALARM = 2'd3;

    localparam int               c_CNT_W      = $clog2(ALARM_SEC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ALARM_SEC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [3:0]       c_MAX_MIN10  = 4'(MAX_MIN / 10);
    localparam logic [3:0]       c_MAX_MIN1   = 4'(MAX_MIN % 10);

    // Registered state
    logic [3:0]         r_min10, r_min1, r_sec10, r_sec1;
    logic [1:0]         r_state;
    logic               r_alarm;
    logic [c_CNT_W-1:0] r_cnt;

    // Next-state values
    logic [3:0]         w_nxt_min10, w_nxt_min1, w_nxt_sec10, w_nxt_sec1;
    logic [1:0]         w_nxt_state;
    logic               w_nxt_alarm;
    logic [c_CNT_W-1:0] w_nxt_cnt;

    // Digit arithmetic results
    logic [3:0] w_inc_min10, w_inc_min1, w_inc_sec10, w_inc_sec1;
    logic [3:0] w_dec_min10, w_dec_min1, w_dec_sec10, w_dec_sec1;
    logic       w_time_nz;
    logic       w_is_one;
    logic       w_any_btn;

    assign w_time_nz = |{r_min10, r_min1, r_sec10, r_sec1};
    // 00:01 is the only value whose decrement lands on 00:00
    assign w_is_one  = ({r_min10, r_min1, r_sec10, r_sec1} == 16'h0001);
    assign w_any_btn = btn_start | btn_inc_min | btn_inc_sec | btn_clear;

    // Seconds increment: 59 wraps to 00 with no carry into minutes
    always_comb begin
        w_inc_sec10 = r_sec10;
        w_inc_sec1  = r_sec1;
        if (r_sec10 == 4'd5 && r_sec1 == 4'd9) begin
            w_inc_sec10 = 4'd0;
            w_inc_sec1  = 4'd0;
        end else if (r_sec1 == 4'd9) begin
            w_inc_sec10 = r_sec10 + 4'd1;
            w_inc_sec1  = 4'd0;
        end else begin
            w_inc_sec1  = r_sec1 + 4'd1;
        end
    end

    // Minutes increment: MAX_MIN wraps to 00
    always_comb begin
        w_inc_min10 = r_min10;
        w_inc_min1  = r_min1;
        if (r_min10 == c_MAX_MIN10 && r_min1 == c_MAX_MIN1) begin
            w_inc_min10 = 4'd0;
            w_inc_min1  = 4'd0;
        end else if (r_min1 == 4'd9) begin
            w_inc_min10 = r_min10 + 4'd1;
            w_inc_min1  = 4'd0;
        end else begin
            w_inc_min1  = r_min1 + 4'd1;
        end
    end

    // One-second BCD decrement with a borrow chain across all four digits.
    // Never applied at 00:00, since RUN always leaves on reaching zero.
    always_comb begin
        w_dec_min10 = r_min10;
        w_dec_min1  = r_min1;
        w_dec_sec10 = r_sec10;
        w_dec_sec1  = r_sec1;
        if (r_sec1 != 4'd0) begin
            w_dec_sec1 = r_sec1 - 4'd1;
        end else begin
            w_dec_sec1 = 4'd9;
            if (r_sec10 != 4'd0) begin
                w_dec_sec10 = r_sec10 - 4'd1;
            end else begin
                w_dec_sec10 = 4'd5;
                if (r_min1 != 4'd0) begin
                    w_dec_min1 = r_min1 - 4'd1;
                end else begin
                    w_dec_min1  = 4'd9;
                    w_dec_min10 = r_min10 - 4'd1;
                end
            end
        end
    end

    // Controller: one action per cycle, priority clear > start > tick > inc
    always_comb begin
        w_nxt_min10 = r_min10;
        w_nxt_min1  = r_min1;
        w_nxt_sec10 = r_sec10;
        w_nxt_sec1  = r_sec1;
        w_nxt_state = r_state;
        w_nxt_alarm = r_alarm;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (btn_clear) begin
                    w_nxt_min10 = 4'd0;
                    w_nxt_min1  = 4'd0;
                    w_nxt_sec10 = 4'd0;
                    w_nxt_sec1  = 4'd0;
                end else if (btn_start) begin
                    if (w_time_nz) begin
                        w_nxt_state = c_ST_RUN;
                    end
                end else begin
                    // tick_sec has no effect in IDLE, so it does not block the inc buttons
                    if (btn_inc_sec) begin
                        w_nxt_sec10 = w_inc_sec10;
                        w_nxt_sec1  = w_inc_sec1;
                    end
                    if (btn_inc_min) begin
                        w_nxt_min10 = w_inc_min10;
                        w_nxt_min1  = w_inc_min1;
                    end
                end
            end
            c_ST_RUN: begin
                if (btn_clear) begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_min10 = 4'd0;
                    w_nxt_min1  = 4'd0;
                    w_nxt_sec10 = 4'd0;
                    w_nxt_sec1  = 4'd0;
                end else if (btn_start) begin
                    w_nxt_state = c_ST_PAUSE;
                end else if (tick_sec) begin
                    w_nxt_min10 = w_dec_min10;
                    w_nxt_min1  = w_dec_min1;
                    w_nxt_sec10 = w_dec_sec10;
                    w_nxt_sec1  = w_dec_sec1;
                    if (w_is_one) begin
                        w_nxt_state = c_ST_ALARM;
                        w_nxt_alarm = 1'b1;
                        w_nxt_cnt   = '0;
                    end
                end
            end
            c_ST_PAUSE: begin
                if (btn_clear) begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_min10 = 4'd0;
                    w_nxt_min1  = 4'd0;
                    w_nxt_sec10 = 4'd0;
                    w_nxt_sec1  = 4'd0;
                end else if (btn_start) begin
                    w_nxt_state = c_ST_RUN;
                end
            end
            c_ST_ALARM: begin
                if (w_any_btn) begin
                    w_nxt_state = c_ST_IDLE;
                    w_nxt_alarm = 1'b0;
                    w_nxt_cnt   = '0;
                end else if (tick_sec) begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_nxt_state = c_ST_IDLE;
                        w_nxt_alarm = 1'b0;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            default: begin
                w_nxt_state = c_ST_IDLE;
                w_nxt_alarm = 1'b0;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_min10 <= 4'd0;
            r_min1  <= 4'd0;
            r_sec10 <= 4'd0;
            r_sec1  <= 4'd0;
            r_state <= c_ST_IDLE;
            r_alarm <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_min10 <= w_nxt_min10;
            r_min1  <= w_nxt_min1;
            r_sec10 <= w_nxt_sec10;
            r_sec1  <= w_nxt_sec1;
            r_state <= w_nxt_state;
            r_alarm <= w_nxt_alarm;
            r_cnt   <= w_nxt_cnt;
        end
    end

    assign min10 = r_min10;
    assign min1  = r_min1;
    assign sec10 = r_sec10;
    assign sec1  = r_sec1;
    assign state = r_state;
    assign alarm = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cook_timer_fsm
//  Description : Self-checking bench for cook_timer_fsm. Expected time is
//                tracked as a plain seconds count and converted to BCD,
//                queued when stimulus is driven and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_timer_fsm;

    localparam int ALARM_SEC = 10;
    localparam int MAX_MIN   = 59;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       tick_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_inc_min = 1'b0;
    logic       btn_inc_sec = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] min10, min1, sec10, sec1;
    logic [1:0] state;
    logic       alarm;

    int checks   = 0;
    int failures = 0;

    logic [18:0] obs;
    logic [18:0] e;
    logic [18:0] exp_q[$];

    assign obs = {min10, min1, sec10, sec1, state, alarm};

    cook_timer_fsm #(
        .ALARM_SEC (ALARM_SEC),
        .MAX_MIN   (MAX_MIN)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .tick_sec    (tick_sec),
        .btn_start   (btn_start),
        .btn_inc_min (btn_inc_min),
        .btn_inc_sec (btn_inc_sec),
        .btn_clear   (btn_clear),
        .min10       (min10),
        .min1        (min1),
        .sec10       (sec10),
        .sec1        (sec1),
        .state       (state),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    // Expected packed output word from a time in seconds
    function automatic logic [18:0] pack(input int s, input logic [1:0] st, input logic al);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), st, al};
    endfunction

    // One clock with the given pulses; returns 1 ns after the edge
    task automatic cyc(input logic clr, input logic st, input logic tk,
                       input logic im, input logic is);
        btn_clear   = clr;
        btn_start   = st;
        tick_sec    = tk;
        btn_inc_min = im;
        btn_inc_sec = is;
        @(posedge clk);
        #1;
        btn_clear   = 1'b0;
        btn_start   = 1'b0;
        tick_sec    = 1'b0;
        btn_inc_min = 1'b0;
        btn_inc_sec = 1'b0;
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
        reset_p = 1'b0;
    endtask

    task automatic test_set_and_async_reset;
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) begin
            s += 1;
            exp_q.push_back(pack(s, 2'd0, 1'b0));
            cyc(0, 0, 0, 0, 1);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL set_sec%0d got=%h exp=%h", k, obs, e); end
        end
        for (int k = 0; k < 2; k++) begin
            s += 60;
            exp_q.push_back(pack(s, 2'd0, 1'b0));
            cyc(0, 0, 0, 1, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL set_min%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL set_start got=%h exp=%h", obs, e); end
        s -= 1;
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL set_tick got=%h exp=%h", obs, e); end
        // Asynchronous reset between clock edges
        #2;
        reset_p = 1'b1;
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        #1;
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, e); end
        #1;
        reset_p = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_countdown;
        int s;
        s = 60;
        exp_q.push_back(pack(s, 2'd0, 1'b0));
        cyc(0, 0, 0, 1, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL cd_set got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL cd_start got=%h exp=%h", obs, e); end
        for (int k = 1; k <= 60; k++) begin
            s = 60 - k;
            exp_q.push_back(pack(s, (s == 0) ? 2'd3 : 2'd1, s == 0));
            cyc(0, 0, 1, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL cd_tick%0d got=%h exp=%h", k, obs, e); end
        end
    endtask

    // Alarm auto-clear: stays for ALARM_SEC-1 ticks, leaves on the last one
    task automatic test_alarm_timeout;
        for (int k = 1; k <= ALARM_SEC; k++) begin
            if (k < ALARM_SEC) exp_q.push_back(pack(0, 2'd3, 1'b1));
            else               exp_q.push_back(pack(0, 2'd0, 1'b0));
            cyc(0, 0, 1, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL alarm_tick%0d got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic enter_alarm;
        exp_q.push_back(pack(1, 2'd0, 1'b0));
        cyc(0, 0, 0, 0, 1);
        exp_q.push_back(pack(1, 2'd1, 1'b0));
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL enter_set got=%h exp=%h", obs, e); end
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL enter_start got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd3, 1'b1));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL enter_alarm got=%h exp=%h", obs, e); end
    endtask

    task automatic test_alarm_buttons;
        enter_alarm();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(pack(0, 2'd3, 1'b1));
            cyc(0, 0, 1, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abtn_tick%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL abtn_clear got=%h exp=%h", obs, e); end
        // inc_min in ALARM exits without touching the digits
        enter_alarm();
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(0, 0, 0, 1, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL abtn_incmin got=%h exp=%h", obs, e); end
        // Counter must have restarted: a full ALARM_SEC window is needed again
        enter_alarm();
        exp_q.push_back(pack(0, 2'd3, 1'b1));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL abtn_hold got=%h exp=%h", obs, e); end
        test_alarm_timeout_from(2);
    endtask

    task automatic test_alarm_timeout_from(input int first);
        for (int k = first; k <= ALARM_SEC; k++) begin
            if (k < ALARM_SEC) exp_q.push_back(pack(0, 2'd3, 1'b1));
            else               exp_q.push_back(pack(0, 2'd0, 1'b0));
            cyc(0, 0, 1, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL arestart_tick%0d got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_pause;
        int s;
        s = 0;
        for (int k = 0; k < 10; k++) begin
            s += 1;
            exp_q.push_back(pack(s, 2'd0, 1'b0));
            cyc(0, 0, 0, 0, 1);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL pz_set%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            s -= 1;
            exp_q.push_back(pack(s, 2'd1, 1'b0));
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); e = exp_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL pz_run got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(s, 2'd2, 1'b0));
        cyc(0, 1, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL pz_enter got=%h exp=%h", obs, e); end
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(pack(s, 2'd2, 1'b0));
            cyc(0, 0, 1, k[0], ~k[0]);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL pz_hold%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL pz_resume got=%h exp=%h", obs, e); end
        s -= 1;
        exp_q.push_back(pack(s, 2'd1, 1'b0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL pz_tick got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(1, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL pz_clear got=%h exp=%h", obs, e); end
    endtask

    task automatic test_wrap;
        for (int k = 1; k <= 60; k++) begin
            exp_q.push_back(pack(k % 60, 2'd0, 1'b0));
            cyc(0, 0, 0, 0, 1);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL wrap_sec%0d got=%h exp=%h", k, obs, e); end
        end
        for (int k = 1; k <= MAX_MIN + 1; k++) begin
            exp_q.push_back(pack((k % (MAX_MIN + 1)) * 60, 2'd0, 1'b0));
            cyc(0, 0, 0, 1, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL wrap_min%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_start0 got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(61, 2'd0, 1'b0));
        cyc(0, 0, 0, 1, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_both got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(61, 2'd0, 1'b0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_idle_tick got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(1, 0, 0, 1, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL wrap_clear got=%h exp=%h", obs, e); end
    endtask

    task automatic test_borrow;
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back(pack(k * 60, 2'd0, 1'b0));
            cyc(0, 0, 0, 1, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL brw_set%0d got=%h exp=%h", k, obs, e); end
        end
        exp_q.push_back(pack(600, 2'd1, 1'b0));
        cyc(0, 1, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL brw_start got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(599, 2'd1, 1'b0));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL brw_tick got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(1, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL brw_clear_tick got=%h exp=%h", obs, e); end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(pack(1, 2'd0, 1'b0));
        cyc(0, 0, 0, 0, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_set got=%h exp=%h", obs, e); end
        // start outranks inc: the inc pulse in the same cycle is dropped
        exp_q.push_back(pack(1, 2'd1, 1'b0));
        cyc(0, 1, 0, 1, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_start_inc got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd3, 1'b1));
        cyc(0, 0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_alarm got=%h exp=%h", obs, e); end
        exp_q.push_back(pack(0, 2'd0, 1'b0));
        cyc(0, 1, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_exit got=%h exp=%h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_set_and_async_reset();
        test_countdown();
        test_alarm_timeout();
        test_alarm_buttons();
        test_pause();
        test_wrap();
        test_borrow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
